// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage issuing ready-handshaked loads/stores to the data RAM and stalling the pipeline until each access completes.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_flag_in,
  input  logic        mem_write_flag_in,
  input  logic        mem_sign_ext_flag_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  input  logic [31:0] current_pc_addr_in,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic        stall_req,
  output logic        bus_error,
  output logic [31:0] result_out,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic [31:0] current_pc_addr_out
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ram_en_d, bus_error_d, is_load_q, is_load_d, sext_q, sext_d, stall;
  logic [3:0] ram_write_en_d, sel_q, sel_d;
  logic [31:0] ram_addr_d, ram_write_data_d, load_q, load_d;
  logic timeout_hit;
  function automatic logic [31:0] rep_data(input logic [3:0] sel, input logic [31:0] d);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: rep_data = {4{d[7:0]}};
      4'b0011, 4'b1100:                   rep_data = {2{d[15:0]}};
      default:                            rep_data = d;
    endcase
  endfunction
  function automatic logic [31:0] extract(input logic [3:0] sel, input logic sx, input logic [31:0] rd);
    case (sel)
      4'b0001: extract = {{24{sx & rd[7]}},  rd[7:0]};
      4'b0010: extract = {{24{sx & rd[15]}}, rd[15:8]};
      4'b0100: extract = {{24{sx & rd[23]}}, rd[23:16]};
      4'b1000: extract = {{24{sx & rd[31]}}, rd[31:24]};
      4'b0011: extract = {{16{sx & rd[15]}}, rd[15:0]};
      4'b1100: extract = {{16{sx & rd[31]}}, rd[31:16]};
      4'b1111: extract = rd;
      default: extract = 32'h0;
    endcase
  endfunction
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ram_en_d = ram_en;
    ram_write_en_d = ram_write_en;
    ram_addr_d = ram_addr;
    ram_write_data_d = ram_write_data;
    load_d = load_q;
    is_load_d = is_load_q;
    sel_d = sel_q;
    sext_d = sext_q;
    bus_error_d = 1'b0;
    stall = 1'b0;
    result_out = result_in;
    case (state_q)
      S_IDLE: if (mem_read_flag_in | mem_write_flag_in) begin
        stall = 1'b1;
        state_d = S_WAIT;
        cnt_d = '0;
        ram_en_d = 1'b1;
        ram_write_en_d = mem_write_flag_in ? mem_sel_in : 4'b0000;
        ram_addr_d = {result_in[31:2], 2'b00};
        ram_write_data_d = rep_data(mem_sel_in, mem_write_data_in);
        is_load_d = ~mem_write_flag_in;
        sel_d = mem_sel_in;
        sext_d = mem_sign_ext_flag_in;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (ram_ready || timeout_hit) begin
          state_d = S_RESP;
          ram_en_d = 1'b0;
          ram_write_en_d = 4'b0000;
          load_d = ram_ready ? extract(sel_q, sext_q, ram_read_data) : 32'h0;
          bus_error_d = ~ram_ready;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        result_out = is_load_q ? load_q : result_in;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // stall is masked by reset so an access cut short by reset releases the pipeline at once
  assign stall_req = stall & rst;
  assign reg_write_en_out = reg_write_en_in & ~stall_req;
  assign reg_write_addr_out = reg_write_addr_in;
  assign current_pc_addr_out = current_pc_addr_in;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ram_en <= 1'b0;
      ram_write_en <= 4'b0000;
      ram_addr <= 32'h0;
      ram_write_data <= 32'h0;
      load_q <= 32'h0;
      is_load_q <= 1'b0;
      sel_q <= 4'b0000;
      sext_q <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ram_en <= ram_en_d;
      ram_write_en <= ram_write_en_d;
      ram_addr <= ram_addr_d;
      ram_write_data <= ram_write_data_d;
      load_q <= load_d;
      is_load_q <= is_load_d;
      sel_q <= sel_d;
      sext_q <= sext_d;
      bus_error <= bus_error_d;
    end
  end
endmodule
